// File: rtl/alu_issue_arbiter_if.sv
// Handshake and ALU bundle between two requesters, one
// consumer, the shared ALU and alu_issue_arbiter.
interface alu_issue_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int FLAG_W = 3
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_instr;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_instr;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [DATA_W-1:0] alu_instruction;
   logic [DATA_W-1:0] alu_regA;
   logic [DATA_W-1:0] alu_regB;
   logic [DATA_W-1:0] alu_result;
   logic [FLAG_W-1:0] alu_flags;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_result;
   logic [FLAG_W-1:0] rsp_flags;

   modport slave (
      input  req0_valid, req0_instr, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_instr, req1_a, req1_b,
      output req1_ready,
      output alu_instruction, alu_regA, alu_regB,
      input  alu_result, alu_flags,
      output rsp_valid, rsp_id, rsp_result, rsp_flags,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_instr, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_instr, req1_a, req1_b,
      input  req1_ready,
      input  alu_instruction, alu_regA, alu_regB,
      output alu_result, alu_flags,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags,
      output rsp_ready
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of one operation at a time from two
// ports onto a shared combinational ALU, with settle wait.
module alu_issue_arbiter #(
   parameter int DATA_W     = 32,
   parameter int FLAG_W     = 3,
   parameter int SETTLE_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   alu_issue_arbiter_if.slave bus,
   output logic busy
);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t           state;
   logic             prio;
   logic [CNT_W-1:0] cnt;
   logic             gnt0;
   logic             gnt1;

   // prio=0 favours port 0 on a tie, prio=1 favours port 1
   always_comb begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || !prio);
      gnt1 = bus.req1_valid && (!bus.req0_valid || prio);
   end

   assign bus.req0_ready = rst_n && (state == IDLE) && gnt0;
   assign bus.req1_ready = rst_n && (state == IDLE) && gnt1;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= IDLE;
         prio                <= 1'b0;
         cnt                 <= '0;
         bus.alu_instruction <= '0;
         bus.alu_regA        <= '0;
         bus.alu_regB        <= '0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_id          <= 1'b0;
         bus.rsp_result      <= '0;
         bus.rsp_flags       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  gnt0: begin
                     bus.alu_instruction <= bus.req0_instr;
                     bus.alu_regA        <= bus.req0_a;
                     bus.alu_regB        <= bus.req0_b;
                     bus.rsp_id          <= 1'b0;
                     prio                <= 1'b1;
                     cnt                 <= CNT_INIT;
                     state               <= ISSUE;
                  end
                  gnt1: begin
                     bus.alu_instruction <= bus.req1_instr;
                     bus.alu_regA        <= bus.req1_a;
                     bus.alu_regB        <= bus.req1_b;
                     bus.rsp_id          <= 1'b1;
                     prio                <= 1'b0;
                     cnt                 <= CNT_INIT;
                     state               <= ISSUE;
                  end
                  default: ;
               endcase
            end
            ISSUE: begin
               if (cnt == '0) begin
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CAPTURE: begin
               bus.rsp_result <= bus.alu_result;
               bus.rsp_flags  <= bus.alu_flags;
               bus.rsp_valid  <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: vector table, contention,
// backpressure, mid-op reset and a SETTLE_CYC=3 build.
module tb_alu_issue_arbiter;
   logic clk;
   logic rst_n;
   logic busy0;
   logic busy3;
   int   nvec;
   int   nerr;

   alu_issue_arbiter_if #(.DATA_W(32), .FLAG_W(3)) bus ();
   alu_issue_arbiter_if #(.DATA_W(32), .FLAG_W(3)) b3 ();

   alu_issue_arbiter #(.DATA_W(32), .FLAG_W(3), .SETTLE_CYC(1)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus),
      .busy (busy0)
   );

   alu_issue_arbiter #(.DATA_W(32), .FLAG_W(3), .SETTLE_CYC(3)) dut3 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b3),
      .busy (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in: flags = {carry, negative, zero}
   function automatic logic [34:0] alu_f(input logic [31:0] ins,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      s = '0;
      r = '0;
      c = 1'b0;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h21: begin
                  s = {1'b0, a} + {1'b0, b};
                  r = s[31:0];
                  c = s[32];
               end
               6'h23: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h26: r = a ^ b;
               default: r = '0;
            endcase
         end
         6'h09: begin
            s = {1'b0, a} + {1'b0, {{16{ins[15]}}, ins[15:0]}};
            r = s[31:0];
            c = s[32];
         end
         6'h0C: r = a & {16'h0, ins[15:0]};
         default: r = '0;
      endcase
      return {c, r[31], (r == 32'h0), r};
   endfunction

   always_comb begin
      {bus.alu_flags, bus.alu_result} =
         alu_f(bus.alu_instruction, bus.alu_regA, bus.alu_regB);
      {b3.alu_flags, b3.alu_result} =
         alu_f(b3.alu_instruction, b3.alu_regA, b3.alu_regB);
   end

   typedef struct {
      logic        port;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   vec_t vt[8];
   exp_t sbq[$];
   exp_t m;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic id,
                       input logic [31:0] r,
                       input logic [2:0] f);
      exp_t e;
      e.id  = id;
      e.res = r;
      e.flg = f;
      sbq.push_back(e);
   endtask

   task automatic drive(input logic p, input logic v,
                        input logic [31:0] i,
                        input logic [31:0] a,
                        input logic [31:0] b);
      if (!p) begin
         bus.req0_valid = v;
         bus.req0_instr = i;
         bus.req0_a     = a;
         bus.req0_b     = b;
      end else begin
         bus.req1_valid = v;
         bus.req1_instr = i;
         bus.req1_a     = a;
         bus.req1_b     = b;
      end
   endtask

   function automatic logic rdy(input logic p);
      return p ? bus.req1_ready : bus.req0_ready;
   endfunction

   // response scoreboard: sees what the next rising edge sees
   always begin
      @(negedge clk);
      #1;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            m = sbq.pop_front();
            chk("rsp_id", 64'(bus.rsp_id), 64'(m.id));
            chk("rsp_result", 64'(bus.rsp_result), 64'(m.res));
            chk("rsp_flags", 64'(bus.rsp_flags), 64'(m.flg));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("sb_drain", 64'(sbq.size()), 64'd0);
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      @(negedge clk);
      drive(v.port, 1'b1, v.instr, v.a, v.b);
      push(v.port, v.res, v.flg);
      #1;
      chk("ready_win", 64'(rdy(v.port)), 64'd1);
      chk("ready_other", 64'(rdy(!v.port)), 64'd0);
      @(negedge clk);
      drive(v.port, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("busy_issue", 64'(busy0), 64'd1);
      chk("alu_instr", 64'(bus.alu_instruction), 64'(v.instr));
      chk("alu_ab", {bus.alu_regA, bus.alu_regB}, {v.a, v.b});
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd2);
      @(negedge clk);
      #1;
      chk("idle_after", {63'd0, busy0}, 64'd0);
      chk("rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
   endtask

   initial begin
      int i0;
      int i1;
      int g;
      int cyc;
      int lat;
      logic [31:0] r0;

      nvec = 0;
      nerr = 0;

      vt[0] = '{1'b0, 32'h0001_0021, 32'h1, 32'hFFFF_FFFE,
                32'hFFFF_FFFF, 3'b010};
      vt[1] = '{1'b1, 32'h2401_7FFF, 32'h7FFF_FFFF, 32'h1,
                32'h8000_7FFE, 3'b010};
      vt[2] = '{1'b0, 32'h0000_0021, 32'h1, 32'hFFFF_FFFF,
                32'h0, 3'b101};
      vt[3] = '{1'b1, 32'h0000_0023, 32'd10, 32'd3,
                32'd7, 3'b000};
      vt[4] = '{1'b0, 32'h0000_0024, 32'hF0F0_F0F0, 32'hFF00_FF00,
                32'hF000_F000, 3'b010};
      vt[5] = '{1'b1, 32'h0000_0025, 32'h1234_0000, 32'h0000_5678,
                32'h1234_5678, 3'b000};
      vt[6] = '{1'b0, 32'h3000_00FF, 32'hABCD_1234, 32'h0,
                32'h0000_0034, 3'b000};
      vt[7] = '{1'b1, 32'h2401_FFFF, 32'h0, 32'h0,
                32'hFFFF_FFFF, 3'b010};

      rst_n = 1'b0;
      drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
      bus.rsp_ready = 1'b1;
      b3.req0_valid = 1'b0;
      b3.req0_instr = '0;
      b3.req0_a     = '0;
      b3.req0_b     = '0;
      b3.req1_valid = 1'b0;
      b3.req1_instr = '0;
      b3.req1_a     = '0;
      b3.req1_b     = '0;
      b3.rsp_ready  = 1'b1;

      // reset state, with both requesters valid
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
      chk("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy0}, 64'd0);
      chk("rst_alu", {bus.alu_instruction, bus.alu_regA}, 64'd0);
      chk("rst_alu_b", 64'(bus.alu_regB), 64'd0);
      chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("rst_rsp", {bus.rsp_result, 28'd0, bus.rsp_flags,
                      bus.rsp_id}, 64'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      rst_n = 1'b1;

      for (int k = 0; k < 8; k++) begin
         run_op(vt[k]);
      end
      wait_drain();

      // contention: both valid throughout, four ops each
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 32'(100 + k), 3'b000);
         push(1'b1, 32'(1000 - k), 3'b000);
      end
      i0 = 0;
      i1 = 0;
      g = 0;
      cyc = 0;
      while ((i0 < 4 || i1 < 4) && cyc < 200) begin
         @(negedge clk);
         cyc++;
         drive(1'b0, i0 < 4, 32'h0000_0021, 32'(i0), 32'd100);
         drive(1'b1, i1 < 4, 32'h0000_0023, 32'd1000, 32'(i1));
         #1;
         if (bus.req0_valid && bus.req0_ready) begin
            chk("grant_seq", 64'd0, 64'(g % 2));
            g++;
            i0++;
         end
         if (bus.req1_valid && bus.req1_ready) begin
            chk("grant_seq", 64'd1, 64'(g % 2));
            g++;
            i1++;
         end
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("grant_count", 64'(g), 64'd8);
      wait_drain();

      // backpressure: hold the response for five cycles
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, vt[0].instr, vt[0].a, vt[0].b);
      push(1'b0, vt[0].res, vt[0].flg);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 32'h0000_0025, 32'h5, 32'h6);
         drive(1'b1, 1'b1, 32'h0000_0025, 32'h7, 32'h8);
         #1;
         chk("bp_ready", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
         chk("bp_busy", {63'd0, busy0}, 64'd1);
         chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
         chk("bp_rsp", {bus.rsp_result, 28'd0, bus.rsp_flags,
                        bus.rsp_id},
             {32'hFFFF_FFFF, 28'd0, 3'b010, 1'b0});
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_idle", {62'd0, busy0, bus.rsp_valid}, 64'd0);
      wait_drain();

      // mid-op reset: port 0 wins, then a second op is aborted
      do_reset();
      run_op(vt[0]);
      @(negedge clk);
      drive(1'b0, 1'b1, vt[2].instr, vt[2].a, vt[2].b);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mr_busy_pre", {63'd0, busy0}, 64'd1);
      @(negedge clk);
      #1;
      chk("mr_busy", {63'd0, busy0}, 64'd0);
      chk("mr_alu", {bus.alu_instruction, bus.alu_regA}, 64'd0);
      chk("mr_alu_b", 64'(bus.alu_regB), 64'd0);
      chk("mr_rsp", {bus.rsp_result, 28'd0, bus.rsp_flags,
                     bus.rsp_id}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("mr_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, vt[0].instr, vt[0].a, vt[0].b);
      drive(1'b1, 1'b1, vt[1].instr, vt[1].a, vt[1].b);
      push(1'b0, vt[0].res, vt[0].flg);
      push(1'b1, vt[1].res, vt[1].flg);
      #1;
      chk("mr_prio", {62'd0, bus.req0_ready, bus.req1_ready},
          64'd2);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      lat = 0;
      #1;
      while (!bus.req1_ready && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("mr_p1_grant", {63'd0, bus.req1_ready}, 64'd1);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      wait_drain();

      // SETTLE_CYC=3 build
      @(negedge clk);
      b3.req1_valid = 1'b1;
      b3.req1_instr = vt[3].instr;
      b3.req1_a     = vt[3].a;
      b3.req1_b     = vt[3].b;
      #1;
      chk("s3_ready", {63'd0, b3.req1_ready}, 64'd1);
      @(negedge clk);
      b3.req1_valid = 1'b0;
      b3.req1_instr = 32'h0;
      #1;
      r0 = vt[3].instr;
      lat = 0;
      while (!b3.rsp_valid && lat < 20) begin
         chk("s3_alu_hold", {b3.alu_instruction, b3.alu_regA},
             {r0, vt[3].a});
         chk("s3_alu_b", 64'(b3.alu_regB), 64'(vt[3].b));
         @(negedge clk);
         #1;
         lat++;
      end
      chk("s3_latency", 64'(lat), 64'd4);
      chk("s3_rsp", {b3.rsp_result, 28'd0, b3.rsp_flags, b3.rsp_id},
          {32'd7, 28'd0, 3'b000, 1'b1});
      @(negedge clk);
      #1;
      chk("s3_idle", {62'd0, busy3, b3.rsp_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end
endmodule
